pu_acc: RTL and testbench
=========================

PU_ACC -- requirements
Module: pu_acc

Interface
REQ-001 Parameter DATA_W, default 5, unsigned width of each input and weight element.
REQ-002 Parameter LANES, default 4, number of multiply lanes; power of two, 2..16.
REQ-003 Parameter OUT_W, default 16, accumulator/output width; SHALL be >= 2*DATA_W+clog2(LANES), checked at elaboration.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_data  input  LANES*DATA_W  packed inputs; lane i at bits [i*DATA_W +: DATA_W].
REQ-007 in_weight  input  LANES*DATA_W  packed weights, same lane packing.
REQ-008 in_valid / in_ready  input / output  1 each  input handshake; beat accepted on edge where both high.
REQ-009 in_mode  input  1  0 = single-shot, 1 = accumulate; sampled with each beat.
REQ-010 in_last  input  1  ends an accumulation group; ignored when in_mode=0.
REQ-011 clr  input  1  synchronous flush of pipeline and accumulator.
REQ-012 out_data  output  OUT_W  result; out_valid / out_ready  output / input  1 each  output handshake.
REQ-013 out_sat  output  1  high with out_valid if any saturation occurred in the group.

Function
REQ-014 Arithmetic SHALL be unsigned: product 2*DATA_W bits, lane sum 2*DATA_W+clog2(LANES) bits, zero-extended to OUT_W.
REQ-015 Pipeline SHALL have three registered stages: S1 lane products, S2 adder-tree sum, S3 accumulator/output register, each with valid, mode and last sideband.
REQ-016 Beat accepted at edge E0 SHALL produce its out_valid from edge E0+2 (single-shot, or last beat of a group) with no stall.
REQ-017 stall = out_valid AND NOT out_ready; in_ready SHALL equal NOT stall; under stall S1, S2, S3 and accumulator SHALL hold.
REQ-018 Bubbles (in_valid low) SHALL propagate as invalid stages; they SHALL not alter the accumulator.
REQ-019 Mode 0 beat at S3: out_data = sum, out_sat = 0, out_valid = 1; accumulator unchanged.
REQ-020 Mode 1 non-last beat at S3: acc = sat(acc + sum); no output.
REQ-021 Mode 1 last beat at S3: out_data = sat(acc + sum), out_valid = 1, out_sat = sticky flag OR this overflow; acc and flag then cleared to 0.
REQ-022 sat(x) SHALL clamp to 2^OUT_W-1 and set the sticky flag.
REQ-023 out_valid SHALL drop on the edge where out_valid AND out_ready unless a new result loads that same edge (back-to-back throughput 1 result/cycle).
REQ-024 A mode-0 beat interleaved inside an open mode-1 group SHALL output its own sum and leave acc intact.
REQ-025 clr SHALL have priority over all events: next edge clears all stage valids, acc, sticky flag, out_valid; in-flight beats are discarded; in_ready is not affected.

Reset
REQ-026 rst high SHALL immediately force out_data=0, out_valid=0, out_sat=0, acc=0, sticky=0, all stage valids=0; in_ready therefore reads 1.
REQ-027 Reset mid-group SHALL abandon the group; first beat after release starts a fresh group from 0.

Structure
REQ-028 Package pu_pkg SHALL hold default DATA_W/LANES/OUT_W constants, the mode enum (MODE_SINGLE, MODE_ACC) and a clog2-based sum-width function.
REQ-029 Sub-module pu_adder_tree (combinational, parametrised LANES and width) SHALL implement the S1->S2 reduction; multipliers and registers remain inline.

Verification (LANES=4, DATA_W=5, OUT_W=16)
REQ-030 Single-shot: in 1,2,3,4 weights 5,6,7,8, mode 0 -> out_data 70, out_sat 0, out_valid two edges after acceptance.
REQ-031 Accumulate: 3 beats all 31x31, last on third -> single output 11532, out_sat 0; no output on first two beats.
REQ-032 Saturation: 18 beats all 31x31, mode 1 -> out_data 65535, out_sat 1; following group of 1x1 (4 lanes) -> 4, out_sat 0.
REQ-033 Backpressure: stream 10 mode-0 beats, out_ready low 5 cycles mid-stream -> in_ready low while stalled, all 10 results in order, none lost or duplicated.
REQ-034 Async rst pulsed between edges after 2 of 3 group beats -> outputs 0 immediately; new 1-beat group 2x3 lanes -> 24.
REQ-035 clr with 2 beats in flight -> no output from them; next single-shot beat produces correct result.

Source files
------------

// File: rtl/pu_pkg.sv
// Shared constants, mode encoding and width helper for the pu_acc block.
package pu_pkg;

    localparam int DEF_DATA_W = 5;
    localparam int DEF_LANES  = 4;
    localparam int DEF_OUT_W  = 16;

    typedef enum logic {
        MODE_SINGLE = 1'b0,
        MODE_ACC    = 1'b1
    } mode_e;

    // Width of the lane sum: one full product plus carry bits for the reduction.
    function automatic int sum_width(input int data_w, input int lanes);
        return 2 * data_w + $clog2(lanes);
    endfunction

endpackage

// File: rtl/pu_adder_tree.sv
// Combinational reduction of LANES unsigned products into one lane sum.
module pu_adder_tree #(
    parameter int LANES = 4,
    parameter int IN_W  = 10,
    parameter int SUM_W = 12
) (
    input  logic [LANES*IN_W-1:0] i_vec,
    output logic [SUM_W-1:0]      o_sum
);

    // Zero-extend every product to the sum width and add them together.
    always_comb begin
        o_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            o_sum = o_sum + SUM_W'(i_vec[i*IN_W +: IN_W]);
        end
    end

endmodule

// File: rtl/pu_acc.sv
// Multiply-accumulate unit: LANES unsigned multipliers, an adder tree and a
// saturating accumulator, in a three-stage pipeline with ready/valid flow
// control on both sides. Stages: S1 products, S2 lane sum, S3 acc/output.
module pu_acc
    import pu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES*DATA_W-1:0] in_weight,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic                    in_last,
    input  logic                    clr,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sat
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = sum_width(DATA_W, LANES);
    localparam int EXT_W  = OUT_W + 1;

    generate
        if (OUT_W < SUM_W) begin : g_bad_out_w
            $error("pu_acc: OUT_W must be at least 2*DATA_W+clog2(LANES)");
        end
        if ((LANES < 2) || (LANES > 16) || ((LANES & (LANES - 1)) != 0)) begin : g_bad_lanes
            $error("pu_acc: LANES must be a power of two in 2..16");
        end
    endgenerate

    logic                    w_stall;
    logic [LANES*PROD_W-1:0] w_prod;
    logic [SUM_W-1:0]        w_tree_sum;
    logic [EXT_W-1:0]        w_acc_ext;
    logic                    w_ovf;
    logic [OUT_W-1:0]        w_acc_sat;

    logic                    r_s1_vld;
    mode_e                   r_s1_mode;
    logic                    r_s1_last;
    logic [LANES*PROD_W-1:0] r_s1_prod;

    logic                    r_s2_vld;
    mode_e                   r_s2_mode;
    logic                    r_s2_last;
    logic [SUM_W-1:0]        r_s2_sum;

    logic [OUT_W-1:0]        r_out_data;
    logic                    r_out_valid;
    logic                    r_out_sat;
    logic [OUT_W-1:0]        r_acc;
    logic                    r_sticky;

    // A presented result that is not taken freezes the whole pipeline.
    assign w_stall   = r_out_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sat   = r_out_sat;

    // Per-lane unsigned products feeding S1.
    always_comb begin
        w_prod = '0;
        for (int i = 0; i < LANES; i++) begin
            w_prod[i*PROD_W +: PROD_W] = PROD_W'(in_data[i*DATA_W +: DATA_W])
                                       * PROD_W'(in_weight[i*DATA_W +: DATA_W]);
        end
    end

    pu_adder_tree #(
        .LANES (LANES),
        .IN_W  (PROD_W),
        .SUM_W (SUM_W)
    ) u_tree (
        .i_vec (r_s1_prod),
        .o_sum (w_tree_sum)
    );

    // Accumulator add with one extra bit to detect overflow, then clamp.
    always_comb begin
        w_acc_ext = EXT_W'(r_acc) + EXT_W'(r_s2_sum);
        w_ovf     = w_acc_ext[OUT_W];
        if (w_ovf) begin
            w_acc_sat = '1;
        end else begin
            w_acc_sat = w_acc_ext[OUT_W-1:0];
        end
    end

    // S1: capture products and sideband of the accepted beat (bubble if none).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_mode <= MODE_SINGLE;
            r_s1_last <= 1'b0;
            r_s1_prod <= '0;
        end else if (clr) begin
            r_s1_vld  <= 1'b0;
        end else if (!w_stall) begin
            r_s1_vld  <= in_valid;
            r_s1_mode <= mode_e'(in_mode);
            r_s1_last <= in_last;
            r_s1_prod <= w_prod;
        end
    end

    // S2: register the reduced lane sum with its sideband.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld  <= 1'b0;
            r_s2_mode <= MODE_SINGLE;
            r_s2_last <= 1'b0;
            r_s2_sum  <= '0;
        end else if (clr) begin
            r_s2_vld  <= 1'b0;
        end else if (!w_stall) begin
            r_s2_vld  <= r_s1_vld;
            r_s2_mode <= r_s1_mode;
            r_s2_last <= r_s1_last;
            r_s2_sum  <= w_tree_sum;
        end
    end

    // S3: single-shot pass-through, group accumulation and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
            r_acc       <= '0;
            r_sticky    <= 1'b0;
        end else if (clr) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
            r_acc       <= '0;
            r_sticky    <= 1'b0;
        end else if (!w_stall) begin
            if (r_s2_vld) begin
                case (r_s2_mode)
                    MODE_SINGLE: begin
                        r_out_data  <= OUT_W'(r_s2_sum);
                        r_out_sat   <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                    MODE_ACC: begin
                        if (r_s2_last) begin
                            r_out_data  <= w_acc_sat;
                            r_out_sat   <= r_sticky | w_ovf;
                            r_out_valid <= 1'b1;
                            r_acc       <= '0;
                            r_sticky    <= 1'b0;
                        end else begin
                            r_acc       <= w_acc_sat;
                            r_sticky    <= r_sticky | w_ovf;
                            r_out_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_out_valid <= 1'b0;
                    end
                endcase
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pu_acc.sv
// Scoreboard bench for pu_acc (LANES=4, DATA_W=5, OUT_W=16).
module tb_pu_acc;

    localparam int DW      = 5;
    localparam int LN      = 4;
    localparam int OW      = 16;
    localparam int VW      = DW * LN;
    localparam int SAT_MAX = 65535;

    logic          clk = 1'b0;
    logic          rst;
    logic [VW-1:0] in_data;
    logic [VW-1:0] in_weight;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic          in_last;
    logic          clr;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sat;

    int n_vec  = 0;
    int n_fail = 0;
    int n_out  = 0;
    int last_out_data = 0;
    int last_out_sat  = 0;
    int exp_data_q[$];
    int exp_sat_q[$];
    int m_acc    = 0;
    int m_sticky = 0;
    bit ready_rand = 1'b0;

    always #5 clk = ~clk;

    pu_acc #(.DATA_W(DW), .LANES(LN), .OUT_W(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_weight (in_weight),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .clr       (clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] rep(input int v);
        logic [VW-1:0] r;
        for (int i = 0; i < LN; i++) r[i*DW +: DW] = v[DW-1:0];
        return r;
    endfunction

    function automatic logic [VW-1:0] pack4(input int a, input int b, input int c, input int d);
        int t[4];
        logic [VW-1:0] r;
        t = '{a, b, c, d};
        for (int i = 0; i < LN; i++) r[i*DW +: DW] = t[i][DW-1:0];
        return r;
    endfunction

    // Reference: dot product of lanes, plain integer arithmetic.
    function automatic int lane_sum(input logic [VW-1:0] d, input logic [VW-1:0] w);
        int s = 0;
        for (int i = 0; i < LN; i++) s += int'(d[i*DW +: DW]) * int'(w[i*DW +: DW]);
        return s;
    endfunction

    task automatic model_accept(input logic [VW-1:0] d, input logic [VW-1:0] w, input bit m, input bit l);
        int s = lane_sum(d, w);
        if (!m) begin
            exp_data_q.push_back(s);
            exp_sat_q.push_back(0);
        end else begin
            m_acc += s;
            if (m_acc > SAT_MAX) begin
                m_acc    = SAT_MAX;
                m_sticky = 1;
            end
            if (l) begin
                exp_data_q.push_back(m_acc);
                exp_sat_q.push_back(m_sticky);
                m_acc    = 0;
                m_sticky = 0;
            end
        end
    endtask

    task automatic model_flush();
        exp_data_q.delete();
        exp_sat_q.delete();
        m_acc    = 0;
        m_sticky = 0;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [VW-1:0] d, input logic [VW-1:0] w, input bit m, input bit l);
        bit ok = 1'b0;
        in_data = d; in_weight = w; in_mode = m; in_last = l; in_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++; n_fail++;
            $display("FAIL accept_timeout: in_ready stayed low, expected beat acceptance");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_accept(d, w, m, l);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_data_q.size() != 0; k++) idle(1);
        check("drain_pending", exp_data_q.size(), 0);
        idle(4);
    endtask

    // Monitor: every output handshake is popped and compared against the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_out++;
            last_out_data = int'(out_data);
            last_out_sat  = int'(out_sat);
            if (exp_data_q.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL unexpected_output: got data %0d sat %0d, expected no output", out_data, out_sat);
            end else begin
                check("out_data", out_data, exp_data_q.pop_front());
                check("out_sat", out_sat, exp_sat_q.pop_front());
            end
        end
    end

    // Random consumer backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int outs_before;
        rst = 1'b1; clr = 1'b0; out_ready = 1'b1;
        in_data = '0; in_weight = '0; in_valid = 1'b0; in_mode = 1'b0; in_last = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1; rst = 1'b0;
        idle(2);

        // Single-shot 1,2,3,4 . 5,6,7,8 with latency check.
        send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b0, 1'b0);
        @(negedge clk); check("lat_edge0_valid", out_valid, 0);
        @(negedge clk); check("lat_edge1_valid", out_valid, 0);
        @(negedge clk); check("lat_edge2_valid", out_valid, 1);
        check("single_data", out_data, 70);
        check("single_sat", out_sat, 0);
        idle(1);
        drain();

        // Three-beat group of 31x31.
        for (int k = 0; k < 3; k++) send_beat(rep(31), rep(31), 1'b1, k == 2);
        drain();
        check("acc3_data", last_out_data, 11532);
        check("acc3_sat", last_out_sat, 0);

        // Saturating group then a clean 1x1 group.
        for (int k = 0; k < 18; k++) send_beat(rep(31), rep(31), 1'b1, k == 17);
        drain();
        check("sat_data", last_out_data, SAT_MAX);
        check("sat_flag", last_out_sat, 1);
        send_beat(rep(1), rep(1), 1'b1, 1'b1);
        drain();
        check("post_sat_data", last_out_data, 4);
        check("post_sat_flag", last_out_sat, 0);

        // Single-shot interleaved inside an open group.
        send_beat(rep(2), rep(2), 1'b1, 1'b0);
        send_beat(rep(1), rep(5), 1'b0, 1'b0);
        send_beat(rep(1), rep(1), 1'b1, 1'b1);
        drain();
        check("interleave_group", last_out_data, 20);

        // Backpressure: 10 single-shot beats with a 5-cycle stall.
        outs_before = n_out;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    logic [VW-1:0] d, w;
                    d = VW'($urandom);
                    w = VW'($urandom);
                    send_beat(d, w, 1'b0, 1'b0);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_result_count", n_out - outs_before, 10);

        // Async reset in the middle of a group with a stalled result.
        out_ready = 1'b0;
        send_beat(rep(7), rep(7), 1'b1, 1'b0);
        send_beat(rep(7), rep(7), 1'b1, 1'b0);
        send_beat(rep(3), rep(3), 1'b0, 1'b0);
        idle(3);
        check("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        check("async_rst_sat", out_sat, 0);
        check("async_rst_in_ready", in_ready, 1);
        model_flush();
        #2 rst = 1'b0;
        out_ready = 1'b1;
        idle(1);
        send_beat(rep(2), rep(3), 1'b1, 1'b1);
        drain();
        check("post_rst_group", last_out_data, 24);

        // clr with two beats in flight.
        send_beat(rep(9), rep(9), 1'b0, 1'b0);
        send_beat(rep(8), rep(8), 1'b0, 1'b0);
        clr = 1'b1;
        #3 check("clr_in_ready", in_ready, 1);
        @(posedge clk); #1 clr = 1'b0;
        model_flush();
        idle(5);
        send_beat(pack4(4, 3, 2, 1), pack4(1, 2, 3, 4), 1'b0, 1'b0);
        drain();
        check("post_clr_single", last_out_data, 20);

        // Randomized traffic with bubbles and random backpressure.
        ready_rand = 1'b1;
        for (int k = 0; k < 300; k++) begin
            logic [VW-1:0] d, w;
            bit m, l;
            d = VW'($urandom);
            w = VW'($urandom);
            m = bit'($urandom_range(0, 1));
            l = ($urandom_range(0, 5) == 0);
            send_beat(d, w, m, l);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        send_beat(rep(1), rep(1), 1'b1, 1'b1);
        ready_rand = 1'b0;
        out_ready  = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
